bs_rr_arbtr_fifo: RTL and testbench
===================================

BS_RR_ARBTR_FIFO -- requirements
Module: bs_rr_arbtr_fifo

Interface
REQ-001 The block SHALL have parameter DRVRS, default 4, number of bus drivers (2..16).
REQ-002 The block SHALL have parameter PCKG_SZ, default 16, packet width in bits (>=16); bits [PCKG_SZ-1:PCKG_SZ-8] hold the destination ID.
REQ-003 The block SHALL have parameter BROADCAST, default 8'hFF, the destination ID meaning all drivers.
REQ-004 The block SHALL have parameter CNT_W, default 16, drop-counter width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port pndng, input, DRVRS, where bit i high means driver i's FIFO head D_pop lane i is valid.
REQ-008 The block SHALL have port D_pop, input, DRVRS*PCKG_SZ, per-driver FIFO head packets with lane i at [i*PCKG_SZ +: PCKG_SZ].
REQ-009 The block SHALL have port pop, output, DRVRS, a one-cycle pulse that consumes driver i's FIFO head.
REQ-010 The block SHALL have port full, input, DRVRS, where bit i high means receiver i cannot accept a push.
REQ-011 The block SHALL have port push, output, DRVRS, which writes the D_push lane into receiver i.
REQ-012 The block SHALL have port D_push, output, DRVRS*PCKG_SZ, with the captured packet replicated on every lane.
REQ-013 The block SHALL have port busy, output, 1, high in any state except IDLE.
REQ-014 The block SHALL have port grant_id, output, $clog2(DRVRS), the index of the last granted driver.
REQ-015 The block SHALL have port drop_cnt, output, CNT_W, the count of dropped packets.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, GRANT and DELIVER, with registered state.
REQ-017 In IDLE with any pndng bit high, the FSM SHALL select the first requester at or after rr_ptr (wrapping modulo DRVRS), register it into grant_id and go to GRANT; if no bit is high it SHALL stay in IDLE.
REQ-018 In GRANT, pop[grant_id] SHALL be high for exactly one cycle, the D_pop lane SHALL be captured into pkt_q, rr_ptr SHALL become grant_id+1 (wrapping), and the FSM SHALL go to DELIVER.
REQ-019 The target mask SHALL be: all drivers except grant_id if dest==BROADCAST, one-hot(dest) if dest<DRVRS and dest!=grant_id, otherwise empty.
REQ-020 If the target mask is empty on entry to DELIVER, there SHALL be no push, drop_cnt SHALL increment by one (saturating at all-ones), and the FSM SHALL return to IDLE.
REQ-021 In DELIVER with a non-empty mask, push SHALL equal the mask in the first cycle where full&mask==0, combinationally from full, for exactly one cycle; the FSM SHALL then go to IDLE.
REQ-022 While any targeted full bit is high, the FSM SHALL hold in DELIVER with push=0; there is no timeout.
REQ-023 Broadcast delivery SHALL be atomic: all targets are pushed in the same cycle.
REQ-024 D_push SHALL equal pkt_q on every lane at all times.
REQ-025 Minimum throughput SHALL be one packet per 3 cycles (IDLE, GRANT, DELIVER); pndng changes during GRANT or DELIVER SHALL have no effect until the next IDLE.
REQ-026 pop and push SHALL never be asserted in the same cycle.

Reset
REQ-027 On reset sampled high, the FSM SHALL go to IDLE and rr_ptr, grant_id, pkt_q and drop_cnt SHALL clear to 0; pop, push and busy SHALL be 0 in the following cycle.
REQ-028 Reset SHALL take priority over all transitions, including mid-DELIVER; the packet in flight SHALL be discarded without a push.

Structure
REQ-029 A shared package bs_pkg SHALL hold the state enum (IDLE/GRANT/DELIVER), ID_W=8 and a function extracting dest from a packet.
REQ-030 Round-robin selection SHALL be one sub-module, rr_prio_sel (inputs req and ptr; outputs gnt_idx and valid), purely combinational.

Verification
REQ-031 The bench SHALL run DRVRS=4, PCKG_SZ=16, checking this case: pndng=4'b0100, lane2=16'h01AB -> pop=4'b0100 for one cycle, next cycle push=4'b0010 and D_push lane1=16'h01AB.
REQ-032 The bench SHALL check this case: pndng=4'b1111 held after reset -> grant_id sequence 0,1,2,3,0 with one pop every 3 cycles.
REQ-033 The bench SHALL check this case: driver0 packet 16'hFF55 -> single-cycle push=4'b1110.
REQ-034 The bench SHALL check this case: driver1 packets 16'h0700 then 16'h0100 -> no push, drop_cnt=2.
REQ-035 The bench SHALL check this case: full[3]=1 for 10 cycles, packet 16'h0312 from driver0 -> push=0 throughout, push[3] in the cycle full[3] falls.
REQ-036 The bench SHALL check this case: reset asserted in DELIVER while full is held -> push never asserts, and the next cycle shows busy=0, drop_cnt=0, and the first grant goes to driver 0.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bs_pkg;

  // Arbiter phases: pick a requester, consume its head, deliver the packet.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    DELIVER = 2'd2
  } bs_state_t;

  // Destination ID field width; the ID sits in the top byte of a packet.
  localparam int ID_W = 8;

  // Widest packet the dest helper accepts; callers zero-extend into this.
  localparam int PKT_MAX_W = 256;

  typedef logic [ID_W-1:0] id_t;

  // Destination ID of a packet that is pkt_w bits wide, passed zero-extended.
  function automatic id_t get_dest(input logic [PKT_MAX_W-1:0] pkt, input int pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bs_rr_arbtr_fifo_rr_prio_sel.sv
// Round-robin priority select: first set req bit at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on gnt_idx/valid.
module rr_prio_sel #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         valid
);

  logic         hi_vld;
  logic [W-1:0] hi_idx;
  logic         lo_vld;
  logic [W-1:0] lo_idx;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    // Walk downwards so the last hit recorded is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (|(req & (N'(1) << i))) begin
        lo_vld = 1'b1;
        lo_idx = W'(i);
        if (W'(i) >= ptr) begin
          hi_vld = 1'b1;
          hi_idx = W'(i);
        end
      end
    end
    valid   = lo_vld;
    gnt_idx = hi_vld ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/bs_rr_arbtr_fifo.sv
// Round-robin bus arbiter: pops one driver FIFO head and pushes it to its target receivers.
// Latency: 3 cycles per packet minimum (select, pop/capture, deliver).
// Backpressure: holds in DELIVER until every targeted receiver is not full; broadcast is all-or-nothing.
module bs_rr_arbtr_fifo
  import bs_pkg::*;
#(
  parameter int          DRVRS     = 4,
  parameter int          PCKG_SZ   = 16,
  parameter logic [7:0]  BROADCAST = 8'hFF,
  parameter int          CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DRVRS-1:0]            pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]    D_pop,
  output logic [DRVRS-1:0]            pop,
  input  logic [DRVRS-1:0]            full,
  output logic [DRVRS-1:0]            push,
  output logic [DRVRS*PCKG_SZ-1:0]    D_push,
  output logic                        busy,
  output logic [$clog2(DRVRS)-1:0]    grant_id,
  output logic [CNT_W-1:0]            drop_cnt
);

  localparam int GW = $clog2(DRVRS);

  bs_state_t          state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [PCKG_SZ-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [GW-1:0]      sel_idx;
  logic               sel_vld;
  logic [PCKG_SZ-1:0] lane_pkt;
  id_t                dest;
  logic [DRVRS-1:0]   grant_oh;
  logic [DRVRS-1:0]   tgt_mask;

  rr_prio_sel #(
    .N (DRVRS),
    .W (GW)
  ) u_sel (
    .req     (pndng),
    .ptr     (rr_ptr_q),
    .gnt_idx (sel_idx),
    .valid   (sel_vld)
  );

  // Head packet of the granted driver, and the captured packet's destination.
  assign lane_pkt = PCKG_SZ'(D_pop >> (int'(grant_id_q) * PCKG_SZ));
  assign dest     = get_dest(PKT_MAX_W'(pkt_q), PCKG_SZ);
  assign grant_oh = DRVRS'(1) << grant_id_q;

  // Receivers the captured packet goes to; a packet never loops back to its source.
  always_comb begin
    tgt_mask = '0;
    if (dest == BROADCAST) begin
      tgt_mask = ~grant_oh;
    end else if ((dest < ID_W'(DRVRS)) && (dest != ID_W'(grant_id_q))) begin
      tgt_mask = DRVRS'(1) << dest;
    end
  end

  // Next-state and output decode; pop/push are suppressed while reset is high.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    pkt_d      = pkt_q;
    drop_cnt_d = drop_cnt_q;
    pop        = '0;
    push       = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          grant_id_d = sel_idx;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        pop      = grant_oh;
        pkt_d    = lane_pkt;
        rr_ptr_d = (grant_id_q == GW'(DRVRS - 1)) ? '0 : grant_id_q + 1'b1;
        state_d  = DELIVER;
      end
      DELIVER: begin
        if (tgt_mask == '0) begin
          // Nobody to deliver to: count the drop and move on.
          if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
          end
          state_d = IDLE;
        end else if ((full & tgt_mask) == '0) begin
          push    = tgt_mask;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      pop  = '0;
      push = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      pkt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      pkt_q      <= pkt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;
  assign drop_cnt = drop_cnt_q;
  assign D_push   = {DRVRS{pkt_q}};

  // Consuming and delivering are separate phases, and only one head is consumed at a time.
  a_pop_push_excl: assert property (@(posedge clk) (pop & push) == '0);
  a_pop_onehot0:   assert property (@(posedge clk) $onehot0(pop));

endmodule

// File: tb/tb_bs_rr_arbtr_fifo.sv
module tb_bs_rr_arbtr_fifo;

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [63:0] D_pop;
  logic [3:0]  pop;
  logic [3:0]  full;
  logic [3:0]  push;
  logic [63:0] D_push;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] drop_cnt;

  bs_rr_arbtr_fifo #(
    .DRVRS     (4),
    .PCKG_SZ   (16),
    .BROADCAST (8'hFF),
    .CNT_W     (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .full     (full),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int push_events = 0;
  bit cmp_en = 0;
  logic [3:0] pop_smp = '0;

  // Per-driver FIFOs feeding the arbiter.
  logic [15:0] dq [4][$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_of(input logic [63:0] v, input int i);
    return v[i*16 +: 16];
  endfunction

  // Receivers a packet from driver gid must reach.
  function automatic logic [3:0] targets(input logic [15:0] pkt, input int gid);
    logic [7:0] d;
    d = pkt[15:8];
    if (d == 8'hFF) return 4'hF & ~(4'(1) << gid);
    if (d < 8'd4 && int'(d) != gid) return 4'(1) << d;
    return 4'h0;
  endfunction

  // Driver FIFO model: consume popped heads, then present the new heads.
  always begin
    logic [15:0] junk;
    logic [3:0]  pn;
    logic [63:0] dp;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (pop_smp[i] && dq[i].size() > 0) junk = dq[i].pop_front();
    #2;
    pn = '0;
    dp = '0;
    for (int i = 0; i < 4; i++) begin
      pn[i] = (dq[i].size() != 0);
      if (dq[i].size() != 0) dp[i*16 +: 16] = dq[i][0];
    end
    pndng = pn;
    D_pop = dp;
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    pop_smp = pop;
    if (push != 4'h0) push_events++;
  end

  // Reference model: transaction phase 0 = waiting, 1 = consuming head, 2 = delivering.
  int          m_step = 0;
  int          m_ptr = 0;
  int          m_gid = 0;
  int          m_drops = 0;
  logic [15:0] m_pkt = '0;

  always @(posedge clk) begin
    logic [3:0] t;
    bit found;
    if (reset) begin
      m_step = 0; m_ptr = 0; m_gid = 0; m_pkt = '0; m_drops = 0;
    end else if (m_step == 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && pndng[(m_ptr + k) % 4]) begin
          found = 1;
          m_gid = (m_ptr + k) % 4;
        end
      end
      if (found) m_step = 1;
    end else if (m_step == 1) begin
      m_pkt  = lane_of(D_pop, m_gid);
      m_ptr  = (m_gid + 1) % 4;
      m_step = 2;
    end else begin
      t = targets(m_pkt, m_gid);
      if (t == 4'h0) begin
        if (m_drops < 65535) m_drops++;
        m_step = 0;
      end else if ((full & t) == 4'h0) begin
        m_step = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [3:0] t, e_pop, e_push;
    if (cmp_en) begin
      t      = targets(m_pkt, m_gid);
      e_pop  = (m_step == 1 && !reset) ? 4'(1) << m_gid : 4'h0;
      e_push = (m_step == 2 && !reset && t != 4'h0 && (full & t) == 4'h0) ? t : 4'h0;
      chk("m_pop", 64'(pop), 64'(e_pop));
      chk("m_push", 64'(push), 64'(e_push));
      chk("m_busy", 64'(busy), 64'(m_step != 0));
      chk("m_grant_id", 64'(grant_id), 64'(m_gid));
      chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drops));
      chk("m_d_push", D_push, {4{m_pkt}});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_pop(input int max, output bit ok);
    ok = 0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk);
      if (pop != 4'h0) ok = 1;
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 0;
    for (int k = 0; k < max && !ok; k++) begin
      @(negedge clk);
      if (!busy && pndng == 4'h0 && dq[0].size() == 0 && dq[1].size() == 0 &&
          dq[2].size() == 0 && dq[3].size() == 0) ok = 1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int ev0;
    int last_cyc;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    full  = 4'h0;
    pndng = 4'h0;
    D_pop = '0;

    // Reset state.
    step();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_push", 64'(push), 64'd0);
    step();
    reset = 1'b0;

    // Unicast from driver 2 to receiver 1.
    dq[2].push_back(16'h01AB);
    wait_pop(10, ok);
    chk("a_pop_seen", 64'(ok), 64'd1);
    chk("a_pop", 64'(pop), 64'h4);
    chk("a_gid", 64'(grant_id), 64'd2);
    @(negedge clk);
    chk("a_pop_off", 64'(pop), 64'h0);
    chk("a_push", 64'(push), 64'h2);
    chk("a_lane1", 64'(D_push[31:16]), 64'h01AB);
    @(negedge clk);
    chk("a_push_off", 64'(push), 64'h0);
    chk("a_idle", 64'(busy), 64'd0);

    // All drivers requesting: rotation and one pop per 3 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dq[i].push_back({8'(i), 8'hB0 + 8'(i)});
      dq[i].push_back({8'(i), 8'hC0 + 8'(i)});
    end
    last_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_pop(10, ok);
      chk("b_pop_seen", 64'(ok), 64'd1);
      chk("b_gid", 64'(grant_id), 64'(exp_seq[n]));
      if (n > 0) chk("b_gap", 64'(cyc - last_cyc), 64'd3);
      last_cyc = cyc;
    end
    wait_idle(60, ok);
    chk("b_drained", 64'(ok), 64'd1);
    chk("b_drops", 64'(drop_cnt), 64'd8);

    // Broadcast from driver 0.
    step();
    dq[0].push_back(16'hFF55);
    wait_pop(10, ok);
    chk("c_pop_seen", 64'(ok), 64'd1);
    chk("c_pop", 64'(pop), 64'h1);
    @(negedge clk);
    chk("c_push", 64'(push), 64'hE);
    chk("c_lane3", 64'(D_push[63:48]), 64'hFF55);
    @(negedge clk);
    chk("c_push_off", 64'(push), 64'h0);

    // Out-of-range destination and self-destination are both dropped.
    do_reset();
    ev0 = push_events;
    dq[1].push_back(16'h0700);
    dq[1].push_back(16'h0100);
    wait_idle(30, ok);
    chk("d_drained", 64'(ok), 64'd1);
    chk("d_drops", 64'(drop_cnt), 64'd2);
    chk("d_no_push", 64'(push_events - ev0), 64'd0);

    // Receiver 3 full for 10 cycles, then released.
    step();
    full = 4'b1000;
    dq[0].push_back(16'h0312);
    wait_pop(10, ok);
    chk("e_pop_seen", 64'(ok), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("e_hold_push", 64'(push), 64'h0);
    end
    chk("e_busy", 64'(busy), 64'd1);
    step();
    full = 4'b0000;
    @(negedge clk);
    chk("e_push", 64'(push), 64'h8);
    chk("e_lane3", 64'(D_push[63:48]), 64'h0312);
    @(negedge clk);
    chk("e_idle", 64'(busy), 64'd0);

    // Reset while stuck in DELIVER: packet discarded, arbitration restarts at 0.
    step();
    ev0 = push_events;
    full = 4'b1000;
    dq[0].push_back(16'h0312);
    wait_pop(10, ok);
    chk("f_pop_seen", 64'(ok), 64'd1);
    @(negedge clk);
    chk("f_busy", 64'(busy), 64'd1);
    step();
    reset = 1'b1;
    dq[0].push_back(16'h0155);
    dq[2].push_back(16'h0166);
    step();
    reset = 1'b0;
    full  = 4'b0000;
    @(negedge clk);
    chk("f_busy_rst", 64'(busy), 64'd0);
    chk("f_drop_rst", 64'(drop_cnt), 64'd0);
    chk("f_no_push", 64'(push_events - ev0), 64'd0);
    wait_pop(10, ok);
    chk("f_pop_seen2", 64'(ok), 64'd1);
    chk("f_first_pop", 64'(pop), 64'h1);
    chk("f_first_gid", 64'(grant_id), 64'd0);
    wait_idle(30, ok);
    chk("f_drained", 64'(ok), 64'd1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
